branch_verify: RTL

BRANCH_VERIFY -- requirements
Module: branch_verify

---
 rtl/branch_verify.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/branch_verify.sv
// branch_verify: resolves the conditional branch sitting in EX against the
// direction fetch predicted for it. On a misprediction it requests a pipeline
// flush with the corrected fetch PC, registers a one-cycle repair bundle for
// the branch predictor, and keeps running counts of resolved branches and
// mispredictions.
module branch_verify (
  input  logic        clk,
  input  logic        rst_n,

  // Instruction in ID: branch class, one-hot branch type, PC, immediate, prediction
  input  logic        B_type_id,
  input  logic        beq_id,
  input  logic        bne_id,
  input  logic        blt_id,
  input  logic        bge_id,
  input  logic        bltu_id,
  input  logic        bgeu_id,
  input  logic [31:0] pc_id,
  input  logic [31:0] imme_id,
  input  logic        B_type_result_id,

  // Fully forwarded operands of the instruction in EX
  input  logic [31:0] rs1_data_ex,
  input  logic [31:0] rs2_data_ex,
  input  logic        PL_stall_ex,

  // Misprediction flush request and corrected fetch PC
  output logic        PL_flush,
  output logic [31:0] pc_rollback,

  // Registered predictor-repair bundle
  output logic        B_type_branch_failed,
  output logic        beq_branch_failed,
  output logic        bne_branch_failed,
  output logic        blt_branch_failed,
  output logic        bge_branch_failed,
  output logic        bltu_branch_failed,
  output logic        bgeu_branch_failed,
  output logic [31:0] pc_branch_filled,
  output logic        B_type_result_branch_failed,

  // Statistics
  output logic [31:0] branch_cnt,
  output logic [31:0] mispredict_cnt
);

  // Branch type vector layout, shared by ID capture, EX evaluation and repair:
  // [0]=beq [1]=bne [2]=blt [3]=bge [4]=bltu [5]=bgeu
  localparam int NTYPE = 6;

  logic [NTYPE-1:0] type_id;

  // ID->EX register set
  logic             valid_ex_reg;
  logic             class_ex_reg;
  logic [NTYPE-1:0] type_ex_reg;
  logic [31:0]      pc_ex_reg;
  logic [31:0]      imme_ex_reg;
  logic             pred_ex_reg;

  // Outcome evaluation
  logic             op_eq;
  logic             op_lt_s;
  logic             op_lt_u;
  logic [NTYPE-1:0] cond_true;
  logic [NTYPE-1:0] type_hit;
  logic             taken;
  logic             branch_live;
  logic             mispredict;
  logic [31:0]      target_pc;
  logic [31:0]      fallthru_pc;

  // Repair bundle state
  logic             repair_class_reg;
  logic             repair_result_reg;
  logic [31:0]      repair_pc_reg;
  logic [NTYPE-1:0] repair_type;

  // Counters
  logic [31:0]      branch_cnt_reg;
  logic [31:0]      mispredict_cnt_reg;

  assign type_id = {bgeu_id, bltu_id, bge_id, blt_id, bne_id, beq_id};

  // ---------------------------------------------------------------------------
  // ID->EX register set. A stalled EX holds its branch so it resolves exactly
  // once, on its first unstalled cycle. A flushing edge loads a bubble so the
  // wrong-path instruction currently in ID can never resolve or flush again.
  // pc/imme still follow ID on a bubble: they only matter for a live branch.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_ex_reg <= 1'b0;
      class_ex_reg <= 1'b0;
      type_ex_reg  <= '0;
      pc_ex_reg    <= '0;
      imme_ex_reg  <= '0;
      pred_ex_reg  <= 1'b0;
    end else if (!PL_stall_ex) begin
      pc_ex_reg   <= pc_id;
      imme_ex_reg <= imme_id;
      if (mispredict) begin
        valid_ex_reg <= 1'b0;
        class_ex_reg <= 1'b0;
        type_ex_reg  <= '0;
        pred_ex_reg  <= 1'b0;
      end else begin
        valid_ex_reg <= 1'b1;
        class_ex_reg <= B_type_id;
        type_ex_reg  <= type_id;
        pred_ex_reg  <= B_type_result_id;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Actual outcome. Operands are re-evaluated every cycle, so while EX is
  // stalled the latest forwarded values decide. Each type pairs with one
  // comparison; a B-class instruction with no type bit set matches nothing
  // and therefore resolves as not taken.
  // ---------------------------------------------------------------------------
  assign op_eq   = (rs1_data_ex == rs2_data_ex);
  assign op_lt_s = ($signed(rs1_data_ex) < $signed(rs2_data_ex));
  assign op_lt_u = (rs1_data_ex < rs2_data_ex);

  assign cond_true = {~op_lt_u, op_lt_u, ~op_lt_s, op_lt_s, ~op_eq, op_eq};

  generate
    for (genvar gi = 0; gi < NTYPE; gi++) begin : g_hit
      assign type_hit[gi] = type_ex_reg[gi] & cond_true[gi];
    end
  endgenerate

  assign taken = |type_hit;

  // A branch only resolves (and is counted) on a cycle where EX advances.
  assign branch_live = valid_ex_reg & class_ex_reg & ~PL_stall_ex;
  assign mispredict  = branch_live & (taken != pred_ex_reg);

  // Corrected fetch PC: both candidates wrap modulo 2^32. Always driven from
  // registered state, so it is 4 straight out of reset.
  assign target_pc   = pc_ex_reg + imme_ex_reg;
  assign fallthru_pc = pc_ex_reg + 32'd4;

  assign PL_flush    = mispredict;
  assign pc_rollback = taken ? target_pc : fallthru_pc;

  // ---------------------------------------------------------------------------
  // Repair bundle: class/result flags pulse for one cycle after a
  // misprediction; the PC of the failed branch is kept until the next one.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      repair_class_reg  <= 1'b0;
      repair_result_reg <= 1'b0;
      repair_pc_reg     <= '0;
    end else begin
      repair_class_reg  <= mispredict;
      repair_result_reg <= mispredict & taken;
      if (mispredict) begin
        repair_pc_reg <= pc_ex_reg;
      end
    end
  end

  // One pulse flag per branch type, marking which kind of branch failed.
  generate
    for (genvar gi = 0; gi < NTYPE; gi++) begin : g_repair_type
      logic flag_reg;

      // Registers the type bit of the mispredicting branch for one cycle
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          flag_reg <= 1'b0;
        end else begin
          flag_reg <= mispredict & type_ex_reg[gi];
        end
      end

      assign repair_type[gi] = flag_reg;
    end
  endgenerate

  assign B_type_branch_failed        = repair_class_reg;
  assign beq_branch_failed           = repair_type[0];
  assign bne_branch_failed           = repair_type[1];
  assign blt_branch_failed           = repair_type[2];
  assign bge_branch_failed           = repair_type[3];
  assign bltu_branch_failed          = repair_type[4];
  assign bgeu_branch_failed          = repair_type[5];
  assign pc_branch_filled            = repair_pc_reg;
  assign B_type_result_branch_failed = repair_result_reg;

  // ---------------------------------------------------------------------------
  // Statistics counters; both wrap naturally at 2^32.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_reg     <= '0;
      mispredict_cnt_reg <= '0;
    end else begin
      if (branch_live) begin
        branch_cnt_reg <= branch_cnt_reg + 32'd1;
      end
      if (mispredict) begin
        mispredict_cnt_reg <= mispredict_cnt_reg + 32'd1;
      end
    end
  end

  assign branch_cnt     = branch_cnt_reg;
  assign mispredict_cnt = mispredict_cnt_reg;

endmodule
